sevseg_count_scan_ctrl: RTL and testbench
=========================================

# sevseg_count_scan_ctrl

Controller between the two debounced pushbuttons and the 4-digit multiplexed seven-segment display. It turns debounced button presses into increment and clear commands on a 4-digit BCD counter. It time-multiplexes the digits onto the shared segment bus with leading-zero blanking. It sits downstream of both debouncers and replaces direct button-to-display wiring in the top level.

## Interface
- SCAN_DIV, 50000: CLK cycles each digit stays selected; legal range 2..2^20.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- BTN_INC  in  1  debounced increment button level, active-high.
- BTN_CLR  in  1  debounced clear button level, active-high.
- AN  out  4  digit anodes, active-low, one-hot-low; AN[0] is the least-significant digit.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low; constant 1 (off).
- COUNT  out  16  BCD count; COUNT[3:0] is the ones digit.

## Operation
- **Edge detect:** one registered copy of each button. A press is a cycle where the input is 1 and its registered copy is 0. Holding a button produces exactly one press.
- **Counter commands:**
  - INC press: BCD increment. A digit at 9 goes to 0 and carries into the next digit.
  - 9999 wraps to 0000. No overflow flag.
  - CLR press: COUNT set to 0000.
  - INC and CLR pressed in the same cycle: clear wins and the increment is dropped.
- **Scan divider:** counter DIV runs 0..SCAN_DIV-1.
  - When DIV = SCAN_DIV-1, DIV returns to 0 and digit index IDX advances 0→1→2→3→0.
  - Width of DIV is clog2(SCAN_DIV).
- **Scan state machine:** four states, DIG0..DIG3, equal to IDX. The only transition is to the next state on a divider wrap. No other input affects the scan.
- **Digit select:** AN = ~(4'b0001 << IDX).
- **Decode:** SEG shows the BCD nibble COUNT[4*IDX+3 : 4*IDX].
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble values 10–15 cannot occur. If forced, they decode to 1111111.
- **Leading-zero blanking:** digit k (k ≥ 1) is blanked (SEG = 1111111) when it and every higher digit are zero. Digit 0 is never blanked. AN still selects a blanked digit.
- **Reset:** takes priority over everything and can be asserted mid-scan or mid-press.
  - COUNT=0000, DIV=0, IDX=0.
  - Both button registers load 1, so a button held through reset does not register a press.
  - On the cycle after RST deasserts: AN=1110, SEG=1000000, DP=1.

## Timing
- COUNT, AN, SEG are all registered outputs. No combinational path from any input to any output.
- Press detected in cycle N (input 1, registered copy 0): COUNT holds the new value from cycle N+1.
- SEG is decoded from the registered COUNT and IDX, so it reflects a COUNT change at cycle N+2 if that digit is selected.
- AN and SEG change on the same edge. Each IDX value is held for exactly SCAN_DIV cycles, so a full frame is 4·SCAN_DIV cycles.
- Button inputs arrive from CLK-domain debouncers; no synchronizer is needed.
- Minimum detectable press: input high for 1 cycle after being low for at least 1 cycle.

## Test plan
Run all scenarios with SCAN_DIV=4.
1. **Reset:** hold RST 3 cycles with BTN_INC=1, then release. Required: AN=1110, SEG=1000000, DP=1, COUNT=0000, and COUNT stays 0000 while BTN_INC remains high.
2. **Single press:** 3-cycle BTN_INC pulse. Required: COUNT=0001 exactly 1 cycle after the rising edge, and no further change. A 20-cycle hold also gives exactly +1.
3. **Carry and wrap:** 9 presses give 0009; the 10th gives 0010. Preload 9999 via presses (or force), then 1 press gives 0000.
4. **Simultaneous press:** with COUNT=0042, BTN_INC and BTN_CLR rise in the same cycle. Required: COUNT=0000 next cycle.
5. **Scan with blanking:** COUNT=0042; observe 16 cycles after a divider wrap. Required sequence, each held 4 cycles:
   - AN=1110 / SEG=0100100
   - AN=1101 / SEG=0011001
   - AN=1011 / SEG=1111111
   - AN=0111 / SEG=1111111
6. **Reset mid-scan:** assert RST while IDX=2 and DIV=1. Required: next cycle IDX=0, AN=1110, DIV=0, COUNT=0000. AN then advances to 1101 after 4 cycles.

Source files
------------

// File: rtl/sevseg_count_scan_ctrl.sv
// Button-driven 4-digit BCD counter with a multiplexed seven-segment scan.
// Leading zeros are blanked, and AN and SEG are registered from the current count and digit index.
module sevseg_count_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BTN_INC,
    input  logic        BTN_CLR,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [15:0] COUNT
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} scan_state_e;

    scan_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             inc_q, clr_q;
    logic [15:0]      count_q, count_d, count_inc;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             inc_press, clr_press, div_wrap;
    logic [3:0]       nib [4];
    logic [3:0]       carry;
    logic [3:0]       zero_hi;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Carry into a digit when every lower digit is 9; a digit is "zero from here up"
    // when it and all higher digits are 0. Both are flat compares, not ripple chains.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib[gi] = count_q[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign carry[gi] = 1'b1;
            end else begin : g_upper
                assign carry[gi] = (count_q[4*gi-1:0] == {gi{4'h9}});
            end
            assign zero_hi[gi] = (count_q[15:4*gi] == '0);
            assign count_inc[4*gi +: 4] = carry[gi] ? ((nib[gi] == 4'd9) ? 4'd0 : nib[gi] + 4'd1)
                                                    : nib[gi];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DIV_W'(1);
        inc_press = BTN_INC & ~inc_q;
        clr_press = BTN_CLR & ~clr_q;
        div_wrap  = (div_q == DIV_LAST);
        count_d   = count_q;
        an_d      = ~(4'b0001 << state_q);
        seg_d     = decode(nib[state_q]);

        if (clr_press) begin
            count_d = 16'h0000;
        end else if (inc_press) begin
            count_d = count_inc;
        end

        if (div_wrap) begin
            div_d = '0;
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
        end

        if (state_q != DIG0 && zero_hi[state_q]) begin
            seg_d = 7'b1111111;
        end
    end

    // Button registers reset to 1 so a button held through reset is not a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inc_q   <= 1'b1;
            clr_q   <= 1'b1;
            count_q <= 16'h0000;
            div_q   <= '0;
            state_q <= DIG0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            inc_q   <= BTN_INC;
            clr_q   <= BTN_CLR;
            count_q <= count_d;
            div_q   <= div_d;
            state_q <= state_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign COUNT = count_q;
    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = 1'b1;
endmodule

// File: tb/tb_sevseg_count_scan_ctrl.sv
// Scoreboard bench: the driver computes expected outputs from an integer counter model,
// and a monitor compares every cycle.
module tb_sevseg_count_scan_ctrl;
    localparam int SD = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BTN_INC = 1'b0;
    logic        BTN_CLR = 1'b0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic [15:0] COUNT;

    sevseg_count_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .CLK(CLK), .RST(RST), .BTN_INC(BTN_INC), .BTN_CLR(BTN_CLR),
        .AN(AN), .SEG(SEG), .DP(DP), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   verbose = 1'b1;

    int   m_cnt = 0;
    int   m_t = 0;
    bit   m_pinc = 1'b1;
    bit   m_pclr = 1'b1;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'b1000000;
            1: seg_of = 7'b1111001;
            2: seg_of = 7'b0100100;
            3: seg_of = 7'b0110000;
            4: seg_of = 7'b0011001;
            5: seg_of = 7'b0010010;
            6: seg_of = 7'b0000010;
            7: seg_of = 7'b1111000;
            8: seg_of = 7'b0000000;
            9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int cnt, input int k);
        int p;
        p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (k > 0 && cnt < p) exp_seg = 7'b1111111;
        else                  exp_seg = seg_of((cnt / p) % 10);
    endfunction

    // Drive one cycle of inputs and push what the outputs must show after the next edge.
    task automatic step(input bit r, input bit inc, input bit clr);
        exp_t e;
        int   k;
        @(negedge CLK);
        RST = r; BTN_INC = inc; BTN_CLR = clr;
        if (r) begin
            m_cnt = 0; m_t = 0; m_pinc = 1'b1; m_pclr = 1'b1;
            e.an  = 4'b1110;
            e.seg = 7'b1000000;
        end else begin
            k     = (m_t / SD) % 4;
            e.an  = ~(4'b0001 << k);
            e.seg = exp_seg(m_cnt, k);
            if (clr && !m_pclr)      m_cnt = 0;
            else if (inc && !m_pinc) m_cnt = (m_cnt + 1) % 10000;
            m_t++;
            m_pinc = inc;
            m_pclr = clr;
        end
        e.cnt = to_bcd(m_cnt);
        q.push_back(e);
    endtask

    task automatic press();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        cyc++;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({COUNT, AN, SEG, DP} !== {e.cnt, e.an, e.seg, 1'b1}) begin
                errors++;
                $display("FAIL outputs cyc=%0d got COUNT=%h AN=%b SEG=%b DP=%b want COUNT=%h AN=%b SEG=%b DP=1",
                         cyc, COUNT, AN, SEG, DP, e.cnt, e.an, e.seg);
            end else if (verbose) begin
                $display("txn cyc=%0d COUNT=%h AN=%b SEG=%b", cyc, COUNT, AN, SEG);
            end
        end
    end

    initial begin
        bit r, inc, clr;
        // Reset held with BTN_INC high, which must not count after release.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        // 3-cycle pulse, then a 20-cycle hold.
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // Carry from 9 to 10.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (10) press();
        // 42, full frame with blanking, then simultaneous INC+CLR.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (42) press();
        repeat (20) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Reset mid-scan, with IDX=2 and DIV=1 at the reset edge.
        repeat (4) press();
        step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        // 9999, then wrap to 0000.
        verbose = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (9999) press();
        verbose = 1'b1;
        repeat (20) step(1'b0, 1'b0, 1'b0);
        press();
        repeat (4) step(1'b0, 1'b0, 1'b0);
        // Random inputs with occasional clear and reset.
        verbose = 1'b0;
        repeat (3000) begin
            inc = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 199) == 0);
            step(r, inc, clr);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
